sudoku_status_hud: RTL and testbench

Parametrised status and monitor front-end between the solver grid and the board's LEDs and seven-segment digits. Tracks solver lifecycle (idle / running / success / failure) and counts solve cycles. Snapshots the cursor position on a key press and cycles the occupancy-mask view (row / column / block) on another. Generalises the fixed single-digit status display to any grid order, with blinking failure indication, a step counter and debounced key handling.

---
 rtl/sudoku_status_hud.sv | 200 ++++++++++++++++++++
 tb/tb_sudoku_status_hud.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sudoku_status_hud.sv
// Solver status HUD: lifecycle FSM, step counter, failure blink,
// debounced cursor snapshot and occupancy-mask view selection.
module sudoku_status_hud #(
  parameter int ORDER     = 3,
  parameter int BLINK_DIV = 25_000_000,
  parameter int STEP_W    = 32,
  localparam int LEN      = ORDER * ORDER,
  localparam int CW       = $clog2(LEN)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              done_success,
  input  logic              done_failure,
  input  logic [CW-1:0]     cursor_row,
  input  logic [CW-1:0]     cursor_col,
  input  logic              key_sample,
  input  logic              key_view,
  input  logic [LEN-1:0]    occ_row,
  input  logic [LEN-1:0]    occ_col,
  input  logic [LEN-1:0]    occ_blk,
  output logic [LEN-1:0]    leds,
  output logic [6:0]        hex_status,
  output logic [6:0]        hex_row,
  output logic [6:0]        hex_col,
  output logic [1:0]        view_mode,
  output logic [STEP_W-1:0] step_count
);

  localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_S     = 7'b0010010;
  localparam logic [6:0] SEG_F     = 7'b0001110;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    SUCCESS,
    FAILURE
  } state_e;

  state_e state_q, state_d;

  logic [STEP_W-1:0] step_q, step_d;
  logic [BW-1:0]     blink_cnt_q, blink_cnt_d;
  logic              blink_vis_q, blink_vis_d;

  logic [1:0] s1_q, s1_d;
  logic [1:0] s2_q, s2_d;
  logic [1:0] p_q, p_d;
  logic [1:0] key_edge;

  logic [6:0]     hex_row_q, hex_row_d;
  logic [6:0]     hex_col_q, hex_col_d;
  logic [1:0]     view_q, view_d;
  logic [LEN-1:0] leds_q, leds_d;

  function automatic logic [6:0] glyph(input logic [CW-1:0] c);
    logic [3:0] v;
    v = 4'(c);
    if (32'(c) >= 32'(LEN)) begin
      glyph = SEG_BLANK;
    end else begin
      unique case (v)
        4'h0: glyph = 7'b1000000;
        4'h1: glyph = 7'b1111001;
        4'h2: glyph = 7'b0100100;
        4'h3: glyph = 7'b0110000;
        4'h4: glyph = 7'b0011001;
        4'h5: glyph = 7'b0010010;
        4'h6: glyph = 7'b0000010;
        4'h7: glyph = 7'b1111000;
        4'h8: glyph = 7'b0000000;
        4'h9: glyph = 7'b0010000;
        4'ha: glyph = 7'b0001000;
        4'hb: glyph = 7'b0000011;
        4'hc: glyph = 7'b1000110;
        4'hd: glyph = 7'b0100001;
        4'he: glyph = 7'b0000110;
        default: glyph = 7'b0001110;
      endcase
    end
  endfunction

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN: begin
        if (done_success)      state_d = SUCCESS;
        else if (done_failure) state_d = FAILURE;
      end
      SUCCESS: if (start) state_d = RUN;
      FAILURE: if (start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    step_d = step_q;
    if (state_q != RUN && state_d == RUN) begin
      step_d = '0;
    end else if (state_q == RUN && step_q != '1) begin
      step_d = step_q + STEP_W'(1);
    end
  end

  // Blink restarts visible whenever FAILURE is (re)entered.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_vis_d = blink_vis_q;
    if (state_q != FAILURE) begin
      blink_cnt_d = '0;
      blink_vis_d = 1'b1;
    end else if (blink_cnt_q == BLINK_MAX) begin
      blink_cnt_d = '0;
      blink_vis_d = ~blink_vis_q;
    end else begin
      blink_cnt_d = blink_cnt_q + BW'(1);
    end
  end

  always_comb begin
    hex_status = SEG_BLANK;
    unique case (state_q)
      IDLE:    hex_status = SEG_BLANK;
      RUN:     hex_status = SEG_DASH;
      SUCCESS: hex_status = SEG_S;
      FAILURE: hex_status = blink_vis_q ? SEG_F : SEG_BLANK;
      default: hex_status = SEG_BLANK;
    endcase
  end

  // bit 0 = key_sample, bit 1 = key_view
  always_comb begin
    s1_d     = {key_view, key_sample};
    s2_d     = s1_q;
    p_d      = s2_q;
    key_edge = s2_q & ~p_q;
  end

  always_comb begin
    hex_row_d = hex_row_q;
    hex_col_d = hex_col_q;
    if (key_edge[0]) begin
      hex_row_d = glyph(cursor_row);
      hex_col_d = glyph(cursor_col);
    end
  end

  always_comb begin
    view_d = view_q;
    if (key_edge[1]) begin
      view_d = (view_q == 2'd2) ? 2'd0 : view_q + 2'd1;
    end
    unique case (view_q)
      2'd1:    leds_d = occ_col;
      2'd2:    leds_d = occ_blk;
      default: leds_d = occ_row;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      step_q      <= '0;
      blink_cnt_q <= '0;
      blink_vis_q <= 1'b1;
      s1_q        <= '0;
      s2_q        <= '0;
      p_q         <= '0;
      hex_row_q   <= SEG_DASH;
      hex_col_q   <= SEG_DASH;
      view_q      <= 2'd0;
      leds_q      <= '0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      blink_cnt_q <= blink_cnt_d;
      blink_vis_q <= blink_vis_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      p_q         <= p_d;
      hex_row_q   <= hex_row_d;
      hex_col_q   <= hex_col_d;
      view_q      <= view_d;
      leds_q      <= leds_d;
    end
  end

  assign leds       = leds_q;
  assign hex_row    = hex_row_q;
  assign hex_col    = hex_col_q;
  assign view_mode  = view_q;
  assign step_count = step_q;

endmodule

// File: tb/tb_sudoku_status_hud.sv
// Directed bench for sudoku_status_hud: lifecycle, blink,
// step saturation, key snapshot and view cycling.
module tb_sudoku_status_hud;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       done_success = 1'b0;
  logic       done_failure = 1'b0;
  logic [3:0] cursor_row = 4'd0;
  logic [3:0] cursor_col = 4'd0;
  logic       key_sample = 1'b0;
  logic       key_view = 1'b0;
  logic [8:0] occ_row = 9'h001;
  logic [8:0] occ_col = 9'h002;
  logic [8:0] occ_blk = 9'h100;

  logic [8:0] leds, leds2;
  logic [6:0] hex_status, hex_status2;
  logic [6:0] hex_row, hex_row2;
  logic [6:0] hex_col, hex_col2;
  logic [1:0] view_mode, view_mode2;
  logic [7:0] step_count;
  logic [3:0] step_count2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sudoku_status_hud #(.ORDER(3), .BLINK_DIV(4), .STEP_W(8)) u_dut (
    .clock(clk), .reset(reset), .start(start),
    .done_success(done_success), .done_failure(done_failure),
    .cursor_row(cursor_row), .cursor_col(cursor_col),
    .key_sample(key_sample), .key_view(key_view),
    .occ_row(occ_row), .occ_col(occ_col), .occ_blk(occ_blk),
    .leds(leds), .hex_status(hex_status),
    .hex_row(hex_row), .hex_col(hex_col),
    .view_mode(view_mode), .step_count(step_count)
  );

  sudoku_status_hud #(.ORDER(3), .BLINK_DIV(4), .STEP_W(4)) u_sat (
    .clock(clk), .reset(reset), .start(start),
    .done_success(done_success), .done_failure(done_failure),
    .cursor_row(cursor_row), .cursor_col(cursor_col),
    .key_sample(key_sample), .key_view(key_view),
    .occ_row(occ_row), .occ_col(occ_col), .occ_blk(occ_blk),
    .leds(leds2), .hex_status(hex_status2),
    .hex_row(hex_row2), .hex_col(hex_col2),
    .view_mode(view_mode2), .step_count(step_count2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    tests++;
    if (hex_status !== 7'b1111111) begin
      fails++;
      $display("FAIL rst_status: got %b want 1111111", hex_status);
    end
    tests++;
    if (hex_row !== 7'b0111111 || hex_col !== 7'b0111111) begin
      fails++;
      $display("FAIL rst_hex: got %b/%b want 0111111", hex_row, hex_col);
    end
    tests++;
    if (view_mode !== 2'd0 || leds !== 9'h000) begin
      fails++;
      $display("FAIL rst_view: got %0d/%h want 0/000", view_mode, leds);
    end
    tests++;
    if (step_count !== 8'd0) begin
      fails++;
      $display("FAIL rst_step: got %0d want 0", step_count);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_run_count();
    start = 1'b1;
    step();
    start = 1'b0;
    tests++;
    if (hex_status !== 7'b0111111 || step_count !== 8'd0) begin
      fails++;
      $display("FAIL run_entry: got %b/%0d want 0111111/0",
               hex_status, step_count);
    end
    repeat (100) step();
    tests++;
    if (hex_status !== 7'b0111111 || step_count !== 8'd100) begin
      fails++;
      $display("FAIL run_100: got %b/%0d want 0111111/100",
               hex_status, step_count);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    tests++;
    if (step_count !== 8'd101) begin
      fails++;
      $display("FAIL run_start_ignored: got %0d want 101", step_count);
    end
  endtask

  task automatic test_success_tie();
    done_success = 1'b1;
    done_failure = 1'b1;
    step();
    done_success = 1'b0;
    done_failure = 1'b0;
    tests++;
    if (hex_status !== 7'b0010010 || step_count !== 8'd102) begin
      fails++;
      $display("FAIL tie_success: got %b/%0d want 0010010/102",
               hex_status, step_count);
    end
    repeat (5) step();
    tests++;
    if (hex_status !== 7'b0010010 || step_count !== 8'd102) begin
      fails++;
      $display("FAIL success_hold: got %b/%0d want 0010010/102",
               hex_status, step_count);
    end
  endtask

  task automatic test_failure_blink();
    logic [6:0] exp;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    done_failure = 1'b1;
    step();
    done_failure = 1'b0;
    for (int i = 0; i < 16; i++) begin
      exp = (((i / 4) % 2) == 0) ? 7'b0001110 : 7'b1111111;
      tests++;
      if (hex_status !== exp) begin
        fails++;
        $display("FAIL blink_%0d: got %b want %b", i, hex_status, exp);
      end
      step();
    end
    tests++;
    if (step_count !== 8'd2) begin
      fails++;
      $display("FAIL fail_step_frozen: got %0d want 2", step_count);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    tests++;
    if (hex_status !== 7'b0111111 || step_count !== 8'd0) begin
      fails++;
      $display("FAIL restart: got %b/%0d want 0111111/0",
               hex_status, step_count);
    end
    step();
    tests++;
    if (step_count !== 8'd1) begin
      fails++;
      $display("FAIL restart_count: got %0d want 1", step_count);
    end
  endtask

  task automatic test_key_sample();
    cursor_row = 4'd8;
    cursor_col = 4'd0;
    key_sample = 1'b1;
    step();
    step();
    tests++;
    if (hex_row !== 7'b0111111 || hex_col !== 7'b0111111) begin
      fails++;
      $display("FAIL key_early: got %b/%b want 0111111", hex_row, hex_col);
    end
    step();
    tests++;
    if (hex_row !== 7'b0000000 || hex_col !== 7'b1000000) begin
      fails++;
      $display("FAIL key_capture: got %b/%b want 0000000/1000000",
               hex_row, hex_col);
    end
    cursor_row = 4'd3;
    cursor_col = 4'd5;
    repeat (7) step();
    tests++;
    if (hex_row !== 7'b0000000 || hex_col !== 7'b1000000) begin
      fails++;
      $display("FAIL key_held: got %b/%b want 0000000/1000000",
               hex_row, hex_col);
    end
    key_sample = 1'b0;
    repeat (3) step();
    key_sample = 1'b1;
    repeat (3) step();
    key_sample = 1'b0;
    tests++;
    if (hex_row !== 7'b0110000 || hex_col !== 7'b0010010) begin
      fails++;
      $display("FAIL key_second: got %b/%b want 0110000/0010010",
               hex_row, hex_col);
    end
    repeat (3) step();
    cursor_row = 4'd12;
    cursor_col = 4'd15;
    key_sample = 1'b1;
    repeat (3) step();
    key_sample = 1'b0;
    tests++;
    if (hex_row !== 7'b1111111 || hex_col !== 7'b1111111) begin
      fails++;
      $display("FAIL key_out_of_range: got %b/%b want 1111111",
               hex_row, hex_col);
    end
    repeat (3) step();
  endtask

  task automatic test_view();
    logic [1:0] exp_v[4] = '{2'd1, 2'd2, 2'd0, 2'd1};
    logic [8:0] exp_l[4] = '{9'h002, 9'h100, 9'h001, 9'h002};
    for (int i = 0; i < 4; i++) begin
      key_view = 1'b1;
      repeat (3) step();
      tests++;
      if (view_mode !== exp_v[i]) begin
        fails++;
        $display("FAIL view_%0d: got %0d want %0d", i, view_mode, exp_v[i]);
      end
      step();
      tests++;
      if (leds !== exp_l[i]) begin
        fails++;
        $display("FAIL leds_%0d: got %h want %h", i, leds, exp_l[i]);
      end
      key_view = 1'b0;
      repeat (3) step();
    end
  endtask

  task automatic test_simultaneous();
    cursor_row = 4'd1;
    cursor_col = 4'd2;
    key_sample = 1'b1;
    key_view = 1'b1;
    repeat (3) step();
    tests++;
    if (hex_row !== 7'b1111001 || hex_col !== 7'b0100100 ||
        view_mode !== 2'd2) begin
      fails++;
      $display("FAIL both_keys: got %b/%b/%0d want 1111001/0100100/2",
               hex_row, hex_col, view_mode);
    end
    step();
    tests++;
    if (leds !== 9'h100) begin
      fails++;
      $display("FAIL both_leds: got %h want 100", leds);
    end
    key_sample = 1'b0;
    key_view = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_saturation_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (20) step();
    tests++;
    if (step_count2 !== 4'hF) begin
      fails++;
      $display("FAIL sat_step: got %h want F", step_count2);
    end
    tests++;
    if (step_count !== 8'd20) begin
      fails++;
      $display("FAIL wide_step: got %0d want 20", step_count);
    end
    cursor_row = 4'd5;
    key_sample = 1'b1;
    key_view = 1'b1;
    step();
    step();
    reset = 1'b1;
    key_sample = 1'b0;
    key_view = 1'b0;
    step();
    tests++;
    if (hex_status !== 7'b1111111 || step_count !== 8'd0 ||
        step_count2 !== 4'd0) begin
      fails++;
      $display("FAIL midrun_reset: got %b/%0d/%0d want 1111111/0/0",
               hex_status, step_count, step_count2);
    end
    tests++;
    if (hex_row !== 7'b0111111 || view_mode !== 2'd0 || leds !== 9'h000) begin
      fails++;
      $display("FAIL midrun_reset_io: got %b/%0d/%h want 0111111/0/000",
               hex_row, view_mode, leds);
    end
    reset = 1'b0;
    repeat (3) step();
    tests++;
    if (hex_row !== 7'b0111111 || view_mode !== 2'd0) begin
      fails++;
      $display("FAIL dropped_edge: got %b/%0d want 0111111/0",
               hex_row, view_mode);
    end
  endtask

  initial begin
    test_reset();
    test_run_count();
    test_success_tie();
    test_failure_blink();
    test_key_sample();
    test_view();
    test_simultaneous();
    test_saturation_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
